aes_axis_tx: RTL
================

Name: aes_axis_tx

Overview:
- Output-side serializer for the zynq_aes stream engine. It takes 128-bit result blocks from the AES controller and emits them as 32-bit AXI4-Stream master beats on the m00_axis port toward the DMA.
- Performs the per-word byte swap the kernel driver expects, so words appear as little-endian 32-bit values.
- Contains a small block buffer so the controller is not stalled while the sink throttles tready.
- Raises tlast on the final word of the final block of a request.

Parameters:
- BLK_S, 128, block width in bits; must equal 4*WORD_S.
- WORD_S, 32, AXI-Stream data width in bits.
- BUF_DEPTH, 2, number of buffered blocks; power of two, 2 or greater.
- SWAP_BYTES, 1, when 1 reverses the byte order within each output word; when 0 passes the word through unchanged.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- blk_i  in  BLK_S  result block; bit BLK_S-1 is the first bit of the block.
- blk_last_i  in  1  marks the last block of the current request.
- blk_valid_i  in  1  block is offered.
- blk_ready_o  out  1  block buffer can accept.
- m00_axis_tdata  out  WORD_S  output word.
- m00_axis_tkeep  out  WORD_S/8  byte enables.
- m00_axis_tlast  out  1  last word of the request.
- m00_axis_tvalid  out  1  word valid.
- m00_axis_tready  in  1  sink ready.
- blk_cnt_o  out  32  number of blocks fully transmitted; wraps modulo 2^32.

Behaviour:
- Reset values (asserted asynchronously while areset is high):
  - tvalid=0, tlast=0, tdata=0, tkeep=0, blk_cnt_o=0.
  - blk_ready_o=1 once the buffer is empty.
  - Word counter, buffer pointers and stored last flags all cleared.
- Reset asserted mid-operation discards every buffered block and any partially sent block. No beat is emitted after reset until a new block is accepted.
- Block accept:
  - A block and its last flag are written to the buffer on a cycle where blk_valid_i and blk_ready_o are both high.
  - blk_ready_o = !full, taken from registered occupancy only. There is no combinational path from m00_axis_tready to blk_ready_o. When the buffer is full, a pop in cycle N raises blk_ready_o in cycle N+1.
- Output path:
  - m00_axis_tvalid = !empty.
  - m00_axis_tdata is the head block's word selected by word_cnt:
    - word 0 = blk[BLK_S-1 -: 32]
    - word 1 = blk[BLK_S-33 -: 32]
    - then in descending order, one 32-bit slice per word.
  - The selected word is byte-swapped when SWAP_BYTES=1: {b0,b1,b2,b3} is emitted as {b3,b2,b1,b0}.
  - tkeep is all ones while tvalid=1, otherwise 0.
  - tlast = tvalid && (word_cnt==3) && head.last.
- AXI-Stream rules:
  - While tvalid=1 and tready=0, tdata, tkeep and tlast hold stable.
  - tvalid, once raised, never drops before the handshake completes.
- Word counter (2 bits):
  - Increments on each handshake (tvalid && tready).
  - A handshake with word_cnt==3 wraps the counter to 0, pops the head block and increments blk_cnt_o.
- Latency and throughput:
  - A block accepted on edge N presents word 0 with tvalid=1 after edge N.
  - With tready held high, throughput is one word per cycle, i.e. 4 cycles per block, with no bubbles between consecutive buffered blocks.
- Boundary cases:
  - Push and pop in the same cycle: occupancy is unchanged, and both take effect.
  - Push while empty: the block becomes head on the next cycle.
  - Pointers wrap modulo BUF_DEPTH.
  - blk_last_i applies only to its own block. Blocks with last=0 never raise tlast.
  - blk_valid_i while full: the block is not taken, and the upstream holds it.

Test Plan:
- Single block 69c4e0d86a7b0430d8cdb78070b4c55a with last=1, tready held 1 -> beats d8e0c469, 30047b6a, 80b7cdd8, 5ac5b470 on 4 consecutive cycles; tlast only on the 4th beat; blk_cnt_o=1.
- Same block with SWAP_BYTES=0 -> beats 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- 3 blocks pushed back-to-back (last=0,0,1), tready held 0 -> first 2 accepted, then blk_ready_o=0. Then tready=1 -> 12 contiguous beats; the third block is accepted on the cycle after the first pop; a single tlast on beat 12; blk_cnt_o=3.
- Oscillating tready (2 cycles low, 6 cycles high) over 4 blocks -> data is stable while stalled, no beat is lost or duplicated, and the word order matches the unthrottled run.
- areset pulsed after beat 2 of a block -> tvalid falls immediately, blk_cnt_o=0. A new block sent afterwards starts at word 0.
- blk_cnt_o preloaded via force to FFFFFFFF, then one block sent -> blk_cnt_o wraps to 0.

Source files
------------

// File: rtl/aes_axis_tx.sv
// ----------------------------------------------------------------------------
// aes_axis_tx : buffers 128-bit AES result blocks and serializes them into
//               32-bit AXI4-Stream beats (optional per-word byte swap).
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_axis_tx #(
  parameter int BLK_S      = 128,
  parameter int WORD_S     = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int SWAP_BYTES = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [BLK_S-1:0]      blk_i,
  input  logic                  blk_last_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  output logic [WORD_S-1:0]     m00_axis_tdata,
  output logic [WORD_S/8-1:0]   m00_axis_tkeep,
  output logic                  m00_axis_tlast,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic [31:0]           blk_cnt_o
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int NWORDS = BLK_S / WORD_S;
  localparam int BYTES  = WORD_S / 8;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [1:0]       LAST_WORD = 2'(NWORDS - 1);

  logic [BLK_S-1:0]     blk_mem_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] last_mem_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     occ_q, occ_d;
  logic [1:0]           word_cnt_q, word_cnt_d;
  logic [31:0]          blk_cnt_q, blk_cnt_d;

  logic                 full_w, empty_w, push_w, hs_w, pop_w;
  logic [BLK_S-1:0]     head_blk_w;
  logic [WORD_S-1:0]    words_w [NWORDS];
  logic [WORD_S-1:0]    word_sel_w, word_out_w;

  assign full_w  = (occ_q == DEPTH_C);
  assign empty_w = (occ_q == '0);
  assign push_w  = blk_valid_i && !full_w;
  assign hs_w    = !empty_w && m00_axis_tready;
  assign pop_w   = hs_w && (word_cnt_q == LAST_WORD);

  assign head_blk_w = blk_mem_q[rd_ptr_q];

  // Word 0 is the most significant slice of the block.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    assign words_w[k] = head_blk_w[BLK_S-1-WORD_S*k -: WORD_S];
  end

  assign word_sel_w = words_w[word_cnt_q];

  if (SWAP_BYTES != 0) begin : g_swap
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      assign word_out_w[8*b +: 8] = word_sel_w[WORD_S-1-8*b -: 8];
    end
  end else begin : g_pass
    assign word_out_w = word_sel_w;
  end

  assign blk_ready_o     = !full_w;
  assign m00_axis_tvalid = !empty_w;
  assign m00_axis_tdata  = empty_w ? '0 : word_out_w;
  assign m00_axis_tkeep  = empty_w ? '0 : '1;
  assign m00_axis_tlast  = !empty_w && (word_cnt_q == LAST_WORD) && last_mem_q[rd_ptr_q];
  assign blk_cnt_o       = blk_cnt_q;

  always_comb begin
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_cnt_d = word_cnt_q;
    blk_cnt_d  = blk_cnt_q;

    if (push_w && !pop_w) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!push_w && pop_w) begin
      occ_d = occ_q - CNT_W'(1);
    end

    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (hs_w) begin
      word_cnt_d = (word_cnt_q == LAST_WORD) ? 2'd0 : word_cnt_q + 2'd1;
    end

    if (pop_w) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      blk_cnt_d = blk_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        blk_mem_q[i] <= '0;
      end
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      word_cnt_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      if (push_w) begin
        blk_mem_q[wr_ptr_q]  <= blk_i;
        last_mem_q[wr_ptr_q] <= blk_last_i;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      word_cnt_q <= word_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

endmodule

`default_nettype wire
